// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch-predictor types, widths and PC slicing helpers
package bp_pkg;

  localparam int PC_W       = 32;
  localparam int BTB_ROWS   = 16;
  localparam int INDEX_BITS = $clog2(BTB_ROWS);
  localparam int TAG_W      = PC_W - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    CTR_SN = 2'b00,
    CTR_WN = 2'b01,
    CTR_WT = 2'b10,
    CTR_ST = 2'b11
  } ctr_e;

  typedef struct packed {
    logic                  valid;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_W-1:0]      tag;
    logic [PC_W-1:0]       target;
    ctr_e                  pred;
    logic                  jump;
  } btb_update_t;

  // Word-aligned PCs: bits [1:0] never take part in indexing or tagging.
  function automatic logic [PC_W-1:0] bp_index(input logic [PC_W-1:0] pc, input int unsigned ib);
    return (pc >> 2) & ((PC_W'(1) << ib) - PC_W'(1));
  endfunction

  function automatic logic [PC_W-1:0] bp_tag(input logic [PC_W-1:0] pc, input int unsigned ib);
    return pc >> (ib + 2);
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - next state of the 2-bit saturating direction counter
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] old_ctr_i,
  input  logic       taken_i,
  input  logic       hit_i,
  input  logic       jump_i,
  output ctr_e       new_ctr_o
);

  always_comb begin
    new_ctr_o = ctr_e'(old_ctr_i);
    if (jump_i) begin
      new_ctr_o = CTR_ST;
    end else if (!hit_i) begin
      // Fresh allocations start weakly taken so one not-taken flips them.
      new_ctr_o = CTR_WT;
    end else if (taken_i) begin
      if (old_ctr_i != 2'b11) new_ctr_o = ctr_e'(old_ctr_i + 2'b01);
    end else begin
      if (old_ctr_i != 2'b00) new_ctr_o = ctr_e'(old_ctr_i - 2'b01);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves branches in EX, issues flush/redirect and BTB updates
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BTB_ROWS   = 16,
  parameter int INDEX_BITS = $clog2(BTB_ROWS),
  parameter int PERF_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ex_valid,
  input  logic                             ex_stall,
  input  logic                             ex_is_branch,
  input  logic                             ex_is_jump,
  input  logic [DATA_WIDTH-1:0]            ex_pc,
  input  logic                             ex_pred_taken,
  input  logic [DATA_WIDTH-1:0]            ex_pred_target,
  input  logic                             ex_btb_hit,
  input  logic [1:0]                       ex_old_ctr,
  input  logic                             ex_actual_taken,
  input  logic [DATA_WIDTH-1:0]            ex_actual_target,
  output logic                             flush,
  output logic [DATA_WIDTH-1:0]            redirect_pc,
  output logic                             upd_valid,
  output logic [INDEX_BITS-1:0]            upd_index,
  output logic [DATA_WIDTH-INDEX_BITS-3:0] upd_tag,
  output logic [DATA_WIDTH-1:0]            upd_target,
  output logic [1:0]                       upd_pred,
  output logic                             upd_type,
  output logic [PERF_WIDTH-1:0]            perf_branches,
  output logic [PERF_WIDTH-1:0]            perf_mispredicts
);

  localparam int TW = DATA_WIDTH - INDEX_BITS - 2;

  logic                  flush_q, flush_d;
  logic [DATA_WIDTH-1:0] redirect_q, redirect_d;
  logic                  upd_valid_q, upd_valid_d;
  logic [INDEX_BITS-1:0] upd_index_q, upd_index_d;
  logic [TW-1:0]         upd_tag_q, upd_tag_d;
  logic [DATA_WIDTH-1:0] upd_target_q, upd_target_d;
  logic [1:0]            upd_pred_q, upd_pred_d;
  logic                  upd_type_q, upd_type_d;
  logic [PERF_WIDTH-1:0] perf_br_q, perf_br_d;
  logic [PERF_WIDTH-1:0] perf_mp_q, perf_mp_d;

  logic accept, mispredict, needs_update;
  ctr_e new_ctr;

  sat_counter2 u_ctr (
    .old_ctr_i (ex_old_ctr),
    .taken_i   (ex_actual_taken),
    .hit_i     (ex_btb_hit),
    .jump_i    (ex_is_jump),
    .new_ctr_o (new_ctr)
  );

  always_comb begin
    // flush_q marks the current EX slot as wrong-path, so it is never consumed.
    accept       = ex_valid & ~ex_stall & ~flush_q & (ex_is_branch | ex_is_jump);
    mispredict   = (ex_pred_taken != ex_actual_taken) |
                   (ex_pred_taken & ex_actual_taken & (ex_pred_target != ex_actual_target));
    needs_update = ex_is_jump | ex_btb_hit | ex_actual_taken;

    flush_d      = accept & mispredict;
    redirect_d   = '0;
    if (flush_d) redirect_d = ex_actual_taken ? ex_actual_target : ex_pc + DATA_WIDTH'(4);

    upd_valid_d  = accept & needs_update;
    upd_index_d  = '0;
    upd_tag_d    = '0;
    upd_target_d = '0;
    upd_pred_d   = '0;
    upd_type_d   = 1'b0;
    if (upd_valid_d) begin
      upd_index_d  = INDEX_BITS'(bp_index(PC_W'(ex_pc), INDEX_BITS));
      upd_tag_d    = TW'(bp_tag(PC_W'(ex_pc), INDEX_BITS));
      upd_target_d = ex_actual_target;
      upd_pred_d   = new_ctr;
      upd_type_d   = ex_is_jump;
    end

    perf_br_d = perf_br_q + PERF_WIDTH'(accept);
    perf_mp_d = perf_mp_q + PERF_WIDTH'(flush_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_q      <= 1'b0;
      redirect_q   <= '0;
      upd_valid_q  <= 1'b0;
      upd_index_q  <= '0;
      upd_tag_q    <= '0;
      upd_target_q <= '0;
      upd_pred_q   <= '0;
      upd_type_q   <= 1'b0;
      perf_br_q    <= '0;
      perf_mp_q    <= '0;
    end else begin
      flush_q      <= flush_d;
      redirect_q   <= redirect_d;
      upd_valid_q  <= upd_valid_d;
      upd_index_q  <= upd_index_d;
      upd_tag_q    <= upd_tag_d;
      upd_target_q <= upd_target_d;
      upd_pred_q   <= upd_pred_d;
      upd_type_q   <= upd_type_d;
      perf_br_q    <= perf_br_d;
      perf_mp_q    <= perf_mp_d;
    end
  end

  assign flush            = flush_q;
  assign redirect_pc      = redirect_q;
  assign upd_valid        = upd_valid_q;
  assign upd_index        = upd_index_q;
  assign upd_tag          = upd_tag_q;
  assign upd_target       = upd_target_q;
  assign upd_pred         = upd_pred_q;
  assign upd_type         = upd_type_q;
  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;

endmodule
